// File: rtl/bcd_digit_serial_adder.sv
// Digit-serial BCD adder: processes one BCD digit per clock, LSD first.
// Optional feature macro: BCD_SUB_EN (adds nine's-complement subtract path
// selected by 'sub'); with the macro undefined every operation is an add.
module bcd_digit_serial_adder #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sub,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  err
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            busy_nxt;
  logic            done_nxt;

  logic [W-1:0]    a_r;
  logic [W-1:0]    b_r;
  logic [W-1:0]    res_r;
  logic            c_r;
  logic [CW-1:0]   cnt;

  logic            accept_c;
  logic            last_c;
  logic [3:0]      a_dig_c;
  logic [3:0]      b_dig_c;
  logic [3:0]      b_eff_c;
  logic [4:0]      t_c;
  logic            carry_c;
  logic [3:0]      dig_c;
  logic [W-1:0]    res_nxt_c;
  logic            bad_c;
  logic            c_init_c;

`ifdef BCD_SUB_EN
  logic            sub_r;
`else
  logic            unused_sub;
  assign unused_sub = sub;
`endif

  // A new operation is accepted from IDLE or DONE; start is ignored in RUN.
  assign accept_c = start && (state != RUN);
  assign last_c   = (state == RUN) && (cnt == CW'(DIGITS - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        if (last_c) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from the next state; registered below so busy/done are flops.
  always_comb begin
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    case (state_nxt)
      RUN:     busy_nxt = 1'b1;
      DONE:    done_nxt = 1'b1;
      default: ;
    endcase
  end

  // Select the operand digits addressed by the digit counter.
  always_comb begin
    a_dig_c = 4'd0;
    b_dig_c = 4'd0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (cnt == CW'(i)) begin
        a_dig_c = a_r[4*i +: 4];
        b_dig_c = b_r[4*i +: 4];
      end
    end
  end

`ifdef BCD_SUB_EN
  // Nine's complement of the B digit when subtracting.
  assign b_eff_c  = sub_r ? 4'(4'd9 - b_dig_c) : b_dig_c;
  assign c_init_c = sub ? ~cin : cin;
`else
  assign b_eff_c  = b_dig_c;
  assign c_init_c = cin;
`endif

  // One decimal digit: binary sum, then +6 correction above nine.
  always_comb begin
    t_c     = 5'(a_dig_c) + 5'(b_eff_c) + 5'(c_r);
    carry_c = (t_c > 5'd9);
    dig_c   = carry_c ? 4'(t_c + 5'd6) : t_c[3:0];
  end

  // Partial result with the current digit merged into its slot.
  always_comb begin
    res_nxt_c = res_r;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (cnt == CW'(i)) begin
        res_nxt_c[4*i +: 4] = dig_c;
      end
    end
  end

  // Flag any captured operand digit that is not a valid BCD digit.
  always_comb begin
    bad_c = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if ((a_r[4*i +: 4] > 4'd9) || (b_r[4*i +: 4] > 4'd9)) begin
        bad_c = 1'b1;
      end
    end
  end

  // Datapath: operand capture, per-digit accumulation, result update on DONE entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
      res_r <= '0;
      c_r   <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      err   <= 1'b0;
`ifdef BCD_SUB_EN
      sub_r <= 1'b0;
`endif
    end else begin
      busy <= busy_nxt;
      done <= done_nxt;
      if (accept_c) begin
        a_r   <= a;
        b_r   <= b;
        c_r   <= c_init_c;
        cnt   <= '0;
        res_r <= '0;
`ifdef BCD_SUB_EN
        sub_r <= sub;
`endif
      end else if (state == RUN) begin
        c_r   <= carry_c;
        res_r <= res_nxt_c;
        cnt   <= cnt + CW'(1);
      end
      if (last_c) begin
        sum  <= res_nxt_c;
        cout <= carry_c;
        err  <= bad_c;
      end
    end
  end

endmodule
